// File: rtl/axil_reg_pkg.sv
// Shared constants and types for the AXI4-Lite register slave.
package axil_reg_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write FSM: which half of the write (address / data) has been captured
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_AW = 2'd1,
        HAVE_W  = 2'd2,
        RESP    = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle; the slave modport is what the register block sees.
interface axil_reg_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready capture register. Clear has priority over a load so
// a beat consumed straight off the bus in its handshake cycle is not kept.
module axil_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             block_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign ready_o = !full_q && !block_i;
    assign full_o  = full_q;
    assign data_o  = data_q;

    // Capture a beat on handshake, drop it when the consumer clears
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-writable 32-bit registers.
// Write address and data are captured independently; reads run in parallel.
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int NUM_REGS = 4
) (
    input  logic            ACLK,
    input  logic            ARESET,
    axil_reg_slave_if.slave s_axi
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    wr_state_e                state_q, state_d;
    logic                     readyEn_q;
    logic                     respBlock;
    logic                     awReady, wReady, awFull, wFull, awHs, wHs;
    logic                     commit, wrOk, arReady, arHs, rdOk;
    logic [IDX_W-1:0]         awIdxHeld, wrIdx, rdIdx;
    logic [STRB_W+DATA_W-1:0] wHeld;
    logic [STRB_W-1:0]        wrStrb;
    logic [DATA_W-1:0]        wrData, rdSel;
    logic [1:0]               bResp_q;
    logic                     rValid_q;
    logic [DATA_W-1:0]        rData_q;
    logic [1:0]               rResp_q;
    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic                     unusedBits;

    assign unusedBits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Hold every READY low until the first edge after reset is released
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) readyEn_q <= 1'b0;
        else        readyEn_q <= 1'b1;
    end

    assign respBlock = !readyEn_q || (state_q == RESP);

    axil_hold_reg #(.WIDTH(IDX_W)) awHold (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .valid_i (s_axi.S_AXI_AWVALID),
        .block_i (respBlock),
        .clear_i (commit),
        .data_i  (s_axi.S_AXI_AWADDR[ADDR_W-1:2]),
        .ready_o (awReady),
        .full_o  (awFull),
        .data_o  (awIdxHeld)
    );

    axil_hold_reg #(.WIDTH(STRB_W + DATA_W)) wHold (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .valid_i (s_axi.S_AXI_WVALID),
        .block_i (respBlock),
        .clear_i (commit),
        .data_i  ({s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA}),
        .ready_o (wReady),
        .full_o  (wFull),
        .data_o  (wHeld)
    );

    assign awHs = s_axi.S_AXI_AWVALID && awReady;
    assign wHs  = s_axi.S_AXI_WVALID && wReady;

    // A half arriving this cycle is used straight off the bus, so the write
    // lands on the edge that completes the second handshake
    assign wrIdx            = awFull ? awIdxHeld : s_axi.S_AXI_AWADDR[ADDR_W-1:2];
    assign {wrStrb, wrData} = wFull ? wHeld : {s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA};
    assign commit = (state_q != RESP) && (awFull || awHs) && (wFull || wHs);
    assign wrOk   = 32'(wrIdx) < 32'(NUM_REGS);

    // Write FSM state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Write FSM next state: wait for whichever half is missing, then respond
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (awHs && wHs) state_d = RESP;
                else if (awHs)   state_d = HAVE_AW;
                else if (wHs)    state_d = HAVE_W;
            end
            HAVE_AW: if (wHs)                  state_d = RESP;
            HAVE_W:  if (awHs)                 state_d = RESP;
            RESP:    if (s_axi.S_AXI_BREADY)   state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Latch the write response when the write commits
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)      bResp_q <= RESP_OKAY;
        else if (commit) bResp_q <= wrOk ? RESP_OKAY : RESP_SLVERR;
    end

    // Register file: byte-lane writes on commit for in-range indices only
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (commit && wrOk) begin
            for (int r = 0; r < NUM_REGS; r++)
                for (int k = 0; k < STRB_W; k++)
                    if (32'(wrIdx) == 32'(r) && wrStrb[k])
                        regs_q[r][8*k +: 8] <= wrData[8*k +: 8];
        end
    end

    assign s_axi.S_AXI_AWREADY = awReady;
    assign s_axi.S_AXI_WREADY  = wReady;
    assign s_axi.S_AXI_BVALID  = (state_q == RESP);
    assign s_axi.S_AXI_BRESP   = bResp_q;

    assign rdIdx   = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
    assign rdOk    = 32'(rdIdx) < 32'(NUM_REGS);
    assign arReady = readyEn_q && !rValid_q;
    assign arHs    = s_axi.S_AXI_ARVALID && arReady;

    // Read mux over the current (pre-write) register contents
    always_comb begin
        rdSel = '0;
        for (int r = 0; r < NUM_REGS; r++)
            if (32'(rdIdx) == 32'(r)) rdSel = regs_q[r];
    end

    // Read response register, held until the master accepts it
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rValid_q <= 1'b0;
            rData_q  <= '0;
            rResp_q  <= RESP_OKAY;
        end else if (arHs) begin
            rValid_q <= 1'b1;
            rData_q  <= rdOk ? rdSel : '0;
            rResp_q  <= rdOk ? RESP_OKAY : RESP_SLVERR;
        end else if (rValid_q && s_axi.S_AXI_RREADY) begin
            rValid_q <= 1'b0;
        end
    end

    assign s_axi.S_AXI_ARREADY = arReady;
    assign s_axi.S_AXI_RVALID  = rValid_q;
    assign s_axi.S_AXI_RDATA   = rData_q;
    assign s_axi.S_AXI_RRESP   = rResp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: two instances (4 and 2 registers)
// share one driver through a select mux; monitors check every response.
module tb_axil_reg_slave;
    import axil_reg_pkg::*;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    int cycle = 0;
    always @(posedge ACLK) cycle <= cycle + 1;

    int total = 0;
    int bad   = 0;

    logic        sel     = 1'b0;
    logic [3:0]  awAddr  = '0;
    logic        awValid = 1'b0;
    logic [31:0] wData   = '0;
    logic [3:0]  wStrb   = '0;
    logic        wValid  = 1'b0;
    logic        bReady  = 1'b1;
    logic [3:0]  arAddr  = '0;
    logic        arValid = 1'b0;
    logic        rReady  = 1'b1;

    logic        awReady, wReady, bValid, arReady, rValid;
    logic [1:0]  bResp, rResp;
    logic [31:0] rData;

    axil_reg_slave_if #(.ADDR_W(4), .DATA_W(32)) ifA ();
    axil_reg_slave_if #(.ADDR_W(4), .DATA_W(32)) ifB ();

    axil_reg_slave #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(4)) dutA (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(ifA.slave));
    axil_reg_slave #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(2)) dutB (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(ifB.slave));

    assign ifA.S_AXI_AWADDR  = awAddr;
    assign ifA.S_AXI_AWPROT  = 3'b010;
    assign ifA.S_AXI_AWVALID = awValid && !sel;
    assign ifA.S_AXI_WDATA   = wData;
    assign ifA.S_AXI_WSTRB   = wStrb;
    assign ifA.S_AXI_WVALID  = wValid && !sel;
    assign ifA.S_AXI_BREADY  = bReady;
    assign ifA.S_AXI_ARADDR  = arAddr;
    assign ifA.S_AXI_ARPROT  = 3'b101;
    assign ifA.S_AXI_ARVALID = arValid && !sel;
    assign ifA.S_AXI_RREADY  = rReady;

    assign ifB.S_AXI_AWADDR  = awAddr;
    assign ifB.S_AXI_AWPROT  = 3'b010;
    assign ifB.S_AXI_AWVALID = awValid && sel;
    assign ifB.S_AXI_WDATA   = wData;
    assign ifB.S_AXI_WSTRB   = wStrb;
    assign ifB.S_AXI_WVALID  = wValid && sel;
    assign ifB.S_AXI_BREADY  = bReady;
    assign ifB.S_AXI_ARADDR  = arAddr;
    assign ifB.S_AXI_ARPROT  = 3'b101;
    assign ifB.S_AXI_ARVALID = arValid && sel;
    assign ifB.S_AXI_RREADY  = rReady;

    assign awReady = sel ? ifB.S_AXI_AWREADY : ifA.S_AXI_AWREADY;
    assign wReady  = sel ? ifB.S_AXI_WREADY  : ifA.S_AXI_WREADY;
    assign bValid  = sel ? ifB.S_AXI_BVALID  : ifA.S_AXI_BVALID;
    assign bResp   = sel ? ifB.S_AXI_BRESP   : ifA.S_AXI_BRESP;
    assign arReady = sel ? ifB.S_AXI_ARREADY : ifA.S_AXI_ARREADY;
    assign rValid  = sel ? ifB.S_AXI_RVALID  : ifA.S_AXI_RVALID;
    assign rData   = sel ? ifB.S_AXI_RDATA   : ifA.S_AXI_RDATA;
    assign rResp   = sel ? ifB.S_AXI_RRESP   : ifA.S_AXI_RRESP;

    typedef struct { logic [1:0] resp; int due; } bExp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; int due; } rExp_t;
    bExp_t bQ[$];
    rExp_t rQ[$];

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timeout waiting for handshake (t=%0t)", name, $time);
    endtask

    // B-channel monitor: latency and response on first presentation, stability while stalled
    logic       bPend = 1'b0;
    logic [1:0] bLast = '0;
    bExp_t      bE;
    always @(negedge ACLK) begin
        if (ARESET) begin
            bPend = 1'b0;
        end else begin
            if (bPend) begin
                checkOutput("bvalid_hold", {31'd0, bValid}, 32'd1);
                checkOutput("bresp_hold", {30'd0, bResp}, {30'd0, bLast});
                checkOutput("awready_stall", {31'd0, awReady}, 32'd0);
                checkOutput("wready_stall", {31'd0, wReady}, 32'd0);
            end
            if (bValid && !bPend) begin
                if (bQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_b: actual=bvalid required=no response");
                end else begin
                    checkOutput("b_latency", cycle, bQ[0].due);
                    checkOutput("bresp", {30'd0, bResp}, {30'd0, bQ[0].resp});
                end
            end
            if (bValid && bReady && bQ.size() != 0) bE = bQ.pop_front();
            bPend = bValid && !bReady;
            bLast = bResp;
        end
    end

    // R-channel monitor: latency, data and response, plus stability while stalled
    logic        rPend = 1'b0;
    logic [31:0] rDLast = '0;
    logic [1:0]  rRLast = '0;
    rExp_t       rE;
    always @(negedge ACLK) begin
        if (ARESET) begin
            rPend = 1'b0;
        end else begin
            if (rPend) begin
                checkOutput("rvalid_hold", {31'd0, rValid}, 32'd1);
                checkOutput("rdata_hold", rData, rDLast);
                checkOutput("rresp_hold", {30'd0, rResp}, {30'd0, rRLast});
                checkOutput("arready_stall", {31'd0, arReady}, 32'd0);
            end
            if (rValid && !rPend) begin
                if (rQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_r: actual=rvalid required=no response");
                end else begin
                    checkOutput("r_latency", cycle, rQ[0].due);
                    checkOutput("rdata", rData, rQ[0].data);
                    checkOutput("rresp", {30'd0, rResp}, {30'd0, rQ[0].resp});
                end
            end
            if (rValid && rReady && rQ.size() != 0) rE = rQ.pop_front();
            rPend  = rValid && !rReady;
            rDLast = rData;
            rRLast = rResp;
        end
    end

    // Drive one write; AW and W each start after their own delay in cycles
    task automatic applyWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int awDelay, input int wDelay, input logic [1:0] expResp);
        logic awDone = 1'b0;
        logic wDone  = 1'b0;
        logic awHs, wHs;
        int   t = 0;
        awAddr = addr;
        wData  = data;
        wStrb  = strb;
        while (!(awDone && wDone)) begin
            awValid = !awDone && (t >= awDelay);
            wValid  = !wDone && (t >= wDelay);
            @(negedge ACLK);
            awHs = awValid && awReady;
            wHs  = wValid && wReady;
            @(posedge ACLK);
            #1;
            if (awHs) awDone = 1'b1;
            if (wHs)  wDone  = 1'b1;
            t++;
            if (t > 60) begin
                reportTimeout("write_handshake");
                break;
            end
        end
        awValid = 1'b0;
        wValid  = 1'b0;
        if (awDone && wDone) bQ.push_back('{resp: expResp, due: cycle});
    endtask

    // Drive one read address and queue the expected response
    task automatic applyRead(input logic [3:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
        logic hs = 1'b0;
        int   t  = 0;
        arAddr  = addr;
        arValid = 1'b1;
        while (!hs) begin
            @(negedge ACLK);
            hs = arValid && arReady;
            @(posedge ACLK);
            #1;
            t++;
            if (!hs && t > 60) begin
                reportTimeout("read_handshake");
                break;
            end
        end
        arValid = 1'b0;
        if (hs) rQ.push_back('{data: expData, resp: expResp, due: cycle});
    endtask

    // Let all queued responses drain before moving on
    task automatic waitIdle();
        int n = 0;
        while ((bQ.size() != 0 || rQ.size() != 0) && n < 40) begin
            @(posedge ACLK);
            n++;
        end
        @(posedge ACLK);
        #1;
        if (bQ.size() != 0 || rQ.size() != 0) begin
            reportTimeout("response_drain");
            bQ.delete();
            rQ.delete();
        end
    endtask

    // Directed scenario sequence
    task automatic applyStimulus();
        // Reset values and READY release timing
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("rst_awready", {31'd0, awReady}, 32'd0);
        checkOutput("rst_wready", {31'd0, wReady}, 32'd0);
        checkOutput("rst_arready", {31'd0, arReady}, 32'd0);
        checkOutput("rst_bvalid", {31'd0, bValid}, 32'd0);
        checkOutput("rst_rvalid", {31'd0, rValid}, 32'd0);
        checkOutput("rst_bresp", {30'd0, bResp}, 32'd0);
        checkOutput("rst_rresp", {30'd0, rResp}, 32'd0);
        checkOutput("rst_rdata", rData, 32'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        #1 checkOutput("ready_before_edge", {31'd0, awReady}, 32'd0);
        @(posedge ACLK);
        #1;
        checkOutput("awready_after_edge", {31'd0, awReady}, 32'd1);
        checkOutput("wready_after_edge", {31'd0, wReady}, 32'd1);
        checkOutput("arready_after_edge", {31'd0, arReady}, 32'd1);

        // Basic write then read-back of every register
        for (int i = 0; i < 4; i++)
            applyWrite(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, RESP_OKAY);
        for (int i = 0; i < 4; i++)
            applyRead(4'(i * 4), 32'(i + 1), RESP_OKAY);
        applyRead(4'h5, 32'h2, RESP_OKAY);
        waitIdle();

        // Handshake ordering: W first, both together, AW first
        applyWrite(4'h0, 32'h10, 4'hF, 3, 0, RESP_OKAY);
        applyWrite(4'h4, 32'h20, 4'hF, 0, 0, RESP_OKAY);
        applyWrite(4'h8, 32'h30, 4'hF, 0, 2, RESP_OKAY);
        applyRead(4'h0, 32'h10, RESP_OKAY);
        applyRead(4'h4, 32'h20, RESP_OKAY);
        applyRead(4'h8, 32'h30, RESP_OKAY);
        waitIdle();

        // Byte strobes
        applyWrite(4'h4, 32'hAABBCCDD, 4'hF, 0, 0, RESP_OKAY);
        applyWrite(4'h4, 32'h11223344, 4'h5, 0, 0, RESP_OKAY);
        applyRead(4'h4, 32'hAA22CC44, RESP_OKAY);
        waitIdle();

        // Read and write of the same register on the same edge sees the old value
        fork
            applyWrite(4'hC, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY);
            applyRead(4'hC, 32'h4, RESP_OKAY);
        join
        waitIdle();
        applyRead(4'hC, 32'hDEADBEEF, RESP_OKAY);
        waitIdle();

        // Back-pressure on both response channels for five cycles
        bReady = 1'b0;
        rReady = 1'b0;
        fork
            applyWrite(4'h0, 32'h77, 4'hF, 0, 0, RESP_OKAY);
            applyRead(4'h8, 32'h30, RESP_OKAY);
        join
        repeat (5) @(posedge ACLK);
        #1;
        bReady = 1'b1;
        rReady = 1'b1;
        @(posedge ACLK);
        #1;
        checkOutput("b_done_first_ready", {31'd0, bValid}, 32'd0);
        checkOutput("r_done_first_ready", {31'd0, rValid}, 32'd0);
        waitIdle();
        applyRead(4'h0, 32'h77, RESP_OKAY);
        waitIdle();

        // Reset while a write response is pending
        bReady = 1'b0;
        applyWrite(4'h0, 32'h55, 4'hF, 0, 0, RESP_OKAY);
        @(negedge ACLK);
        #1 ARESET = 1'b1;
        #1;
        checkOutput("bvalid_async_clear", {31'd0, bValid}, 32'd0);
        checkOutput("awready_in_reset", {31'd0, awReady}, 32'd0);
        bQ.delete();
        rQ.delete();
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        bReady = 1'b1;
        @(posedge ACLK);
        #1;
        applyRead(4'h0, 32'h0, RESP_OKAY);
        waitIdle();

        // Two-register instance: out-of-range accesses
        sel = 1'b1;
        @(posedge ACLK);
        #1;
        applyWrite(4'h0, 32'hA5A5A5A5, 4'hF, 0, 0, RESP_OKAY);
        applyWrite(4'h4, 32'h5A5A5A5A, 4'hF, 0, 0, RESP_OKAY);
        applyWrite(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_SLVERR);
        applyRead(4'hC, 32'h0, RESP_SLVERR);
        applyRead(4'h8, 32'h0, RESP_SLVERR);
        applyRead(4'h0, 32'hA5A5A5A5, RESP_OKAY);
        applyRead(4'h4, 32'h5A5A5A5A, RESP_OKAY);
        waitIdle();
        sel = 1'b0;
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 Parameter: DATA_W, 32, data bus width in bits; only 32 is supported.
REQ-002 Parameter: ADDR_W, 4, byte-address width.
REQ-003 Parameter: NUM_REGS, 4, number of 32-bit read/write registers; must be <= 2**(ADDR_W-2).
REQ-004 Port: ACLK  in  1  single clock; all logic on its rising edge.
REQ-005 Port: ARESET  in  1  asynchronous, active-high reset.
REQ-006 Ports: S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  AXI4-Lite write-address channel.
REQ-007 Ports: S_AXI_WDATA in DATA_W, S_AXI_WSTRB in DATA_W/8, S_AXI_WVALID in 1, S_AXI_WREADY out 1  AXI4-Lite write-data channel.
REQ-008 Ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  AXI4-Lite write-response channel.
REQ-009 Ports: S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  AXI4-Lite read-address channel.
REQ-010 Ports: S_AXI_RDATA out DATA_W, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  AXI4-Lite read-data channel.

Function
REQ-011 AW and W SHALL each be captured into an independent holding register; either may arrive first or both in the same cycle.
REQ-012 AWREADY SHALL be high when the AW holder is empty and BVALID is low; WREADY likewise for the W holder.
REQ-013 The write FSM SHALL use states IDLE, HAVE_AW, HAVE_W, RESP: IDLE->HAVE_AW on an AW-only handshake, IDLE->HAVE_W on a W-only handshake, IDLE->RESP on both, HAVE_AW/HAVE_W->RESP on the missing handshake, RESP->IDLE on BVALID&&BREADY.
REQ-014 The register update and BVALID assertion SHALL occur on the clock edge following the later of the AW and W handshakes (1-cycle latency).
REQ-015 The word index SHALL be AWADDR[ADDR_W-1:2]; address bits [1:0] and AWPROT/ARPROT SHALL be ignored.
REQ-016 For an index < NUM_REGS, byte lane k SHALL be written only when WSTRB[k]=1, and BRESP SHALL be 2'b00 (OKAY).
REQ-017 For an index >= NUM_REGS, no register SHALL change and BRESP SHALL be 2'b10 (SLVERR).
REQ-018 BVALID and BRESP SHALL stay stable until BREADY is sampled high; only one write SHALL be outstanding.
REQ-019 ARREADY SHALL be high whenever RVALID is low; on ARVALID&&ARREADY, RVALID SHALL assert on the next edge (1-cycle latency).
REQ-020 RDATA SHALL hold the register value sampled in the AR handshake cycle, or 0 with RRESP=2'b10 when the index >= NUM_REGS; otherwise RRESP SHALL be 2'b00.
REQ-021 RVALID, RDATA and RRESP SHALL stay stable until RREADY is sampled high; only one read SHALL be outstanding.
REQ-022 When a read samples a register on the same edge that commits a write to it, the read SHALL return the pre-write value.
REQ-023 The read and write paths SHALL operate concurrently and independently, with no mutual stalling.

Reset
REQ-024 While ARESET is high: all registers = 0, holders empty, write FSM = IDLE, and AWREADY=WREADY=ARREADY=BVALID=RVALID=0, with BRESP=RRESP=0 and RDATA=0.
REQ-025 An assertion of ARESET mid-transaction SHALL abandon any pending B or R response immediately, with no partial register write.
REQ-026 The READY outputs SHALL rise no earlier than the first ACLK edge after ARESET deasserts.

Structure
REQ-027 Package axil_reg_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the write-FSM state enum, and the DATA_W/ADDR_W defaults.
REQ-028 A single sub-module, axil_hold_reg (a valid/ready capture register with a clear input), SHALL be instantiated twice, for the AW holder and the W holder.

Verification
REQ-029 Scenario: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read each address -> the same data is returned with all BRESP and RRESP = OKAY.
REQ-030 Scenario: W presented 3 cycles before AW, then AW and W together in one cycle -> each write gets exactly one BVALID, 1 cycle after the later handshake.
REQ-031 Scenario: write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB=0x5 -> a read of 0x4 returns 0xAA22CC44.
REQ-032 Scenario: with NUM_REGS=2, write to 0x8 and read from 0xC -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, and registers are unchanged.
REQ-033 Scenario: BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and their data stay stable, AWREADY/WREADY/ARREADY stay low, and the transfer completes on the first ready cycle.
REQ-034 Scenario: ARESET pulsed while BVALID=1 after a write of 0x55 to 0x0 -> BVALID=0 at once, and a read of 0x0 after reset returns 0.
